exception_sequencer: RTL and testbench

- Multi-cycle controller that sequences exception entry for the multicycle MIPS core.
- On an overflow or invalid-opcode event it:
  - saves the faulting PC into EPC;
  - reads the handler vector byte from memory (one fixed vector address per cause);
  - loads the zero-extended vector into PC.
- Sits beside the main control unit and takes control of the memory address mux, EPC write and PC write for the duration of entry.

---
 rtl/exception_sequencer_if.sv | 29 ++
 rtl/exception_sequencer.sv | 98 +++++++++
 tb/tb_exception_sequencer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/exception_sequencer_if.sv
// rtl/exception_sequencer_if.sv - event, memory and PC/EPC control signals of the exception sequencer
interface exception_sequencer_if;
    logic        ovf_evt;
    logic        opcode_evt;
    logic        exc_enable;
    logic [31:0] mem_data_in;
    logic        exc_busy;
    logic [31:0] mem_addr;
    logic        mem_addr_sel;
    logic        mem_read;
    logic        epc_write;
    logic        pc_write;
    logic        pc_src_exc;
    logic [31:0] new_pc;
    logic [1:0]  cause;
    logic        exc_done;

    modport master (
        output ovf_evt, opcode_evt, exc_enable, mem_data_in,
        input  exc_busy, mem_addr, mem_addr_sel, mem_read, epc_write,
               pc_write, pc_src_exc, new_pc, cause, exc_done
    );

    modport slave (
        input  ovf_evt, opcode_evt, exc_enable, mem_data_in,
        output exc_busy, mem_addr, mem_addr_sel, mem_read, epc_write,
               pc_write, pc_src_exc, new_pc, cause, exc_done
    );
endinterface

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - multi-cycle exception entry: save EPC, fetch vector byte, load PC
module exception_sequencer #(
    parameter int          MEM_LATENCY     = 1,
    parameter logic [31:0] VEC_ADDR_OPCODE = 32'd254,
    parameter logic [31:0] VEC_ADDR_OVF    = 32'd255
) (
    input  logic                  clk,
    input  logic                  reset,
    exception_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_SAVE, S_REQ, S_WAIT, S_LOAD} state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LATENCY - 1);

    state_t      state;
    state_t      next;
    logic [2:0]  cnt;
    logic [1:0]  cause_q;
    logic [31:0] new_pc_q;
    logic        accept;
    logic        unused_data_hi;

    assign accept         = (state == S_IDLE) && bus.exc_enable && (bus.ovf_evt || bus.opcode_evt);
    assign unused_data_hi = ^bus.mem_data_in[31:8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  if (accept) next = S_SAVE;
            S_SAVE:  next = S_REQ;
            S_REQ:   next = S_WAIT;
            S_WAIT:  if (cnt == 3'd0) next = S_LOAD;
            S_LOAD:  next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    // Cause is latched only on acceptance, so events seen mid-sequence never disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= 3'd0;
            cause_q  <= 2'b00;
            new_pc_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: if (accept) cause_q <= bus.ovf_evt ? 2'b10 : 2'b01;
                S_REQ:  cnt <= LAT_M1;
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        new_pc_q <= {24'b0, bus.mem_data_in[7:0]};
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.exc_busy     = 1'b0;
        bus.mem_addr     = 32'd0;
        bus.mem_addr_sel = 1'b0;
        bus.mem_read     = 1'b0;
        bus.epc_write    = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src_exc   = 1'b0;
        bus.exc_done     = 1'b0;
        bus.new_pc       = new_pc_q;
        bus.cause        = cause_q;
        if (state != S_IDLE) begin
            bus.exc_busy = 1'b1;
            bus.mem_addr = (cause_q == 2'b10) ? VEC_ADDR_OVF : VEC_ADDR_OPCODE;
        end
        case (state)
            S_SAVE: bus.epc_write = 1'b1;
            S_REQ: begin
                bus.mem_addr_sel = 1'b1;
                bus.mem_read     = 1'b1;
            end
            S_WAIT: bus.mem_addr_sel = 1'b1;
            S_LOAD: begin
                bus.pc_src_exc = 1'b1;
                bus.pc_write   = 1'b1;
                bus.exc_done   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - two latency variants driven together against a timeline reference model
module tb_exception_sequencer;
    localparam int L0 = 1;
    localparam int L1 = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exception_sequencer_if i0();
    exception_sequencer_if i1();

    exception_sequencer #(.MEM_LATENCY(L0)) dut0 (.clk(clk), .reset(reset), .bus(i0.slave));
    exception_sequencer #(.MEM_LATENCY(L1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));

    int checks = 0;
    int errors = 0;

    // Reference: each accepted event opens a window starting at SAVE cycle st; all outputs follow from offset.
    bit          act [2];
    int          st  [2];
    logic [1:0]  mc  [2];
    logic [31:0] mpc [2];
    int          lat [2];
    int          rdc [2];
    logic [31:0] rda [2];
    logic [31:0] w254, w255;
    int          cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] vec(input logic [1:0] c);
        return (c == 2'b10) ? 32'd255 : 32'd254;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'd254) return w254;
        if (a == 32'd255) return w255;
        return $urandom;
    endfunction

    task automatic get_out(input int k, output logic [6:0] s, output logic [31:0] a,
                           output logic [31:0] p, output logic [1:0] c);
        if (k == 0) begin
            s = {i0.exc_busy, i0.mem_addr_sel, i0.mem_read, i0.epc_write, i0.pc_write, i0.pc_src_exc, i0.exc_done};
            a = i0.mem_addr; p = i0.new_pc; c = i0.cause;
        end else begin
            s = {i1.exc_busy, i1.mem_addr_sel, i1.mem_read, i1.epc_write, i1.pc_write, i1.pc_src_exc, i1.exc_done};
            a = i1.mem_addr; p = i1.new_pc; c = i1.cause;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0; st[k] = 0; mc[k] = 2'b00; mpc[k] = 32'd0; rdc[k] = -100;
        end
    endtask

    task automatic model_edge(input bit ov, input bit op, input bit en);
        if (reset) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (act[k]) begin
                if (cyc - st[k] == 1 + lat[k]) mpc[k] = {24'b0, word_at(vec(mc[k]))[7:0]};
                if (cyc - st[k] == 2 + lat[k]) act[k] = 1'b0;
            end else if (en && (ov || op)) begin
                act[k] = 1'b1;
                st[k]  = cyc + 1;
                mc[k]  = ov ? 2'b10 : 2'b01;
            end
        end
    endtask

    task automatic drive_mem();
        logic [6:0]  s;
        logic [31:0] a, p, d;
        logic [1:0]  c;
        for (int k = 0; k < 2; k++) begin
            get_out(k, s, a, p, c);
            if (s[4]) begin
                rdc[k] = cyc;
                rda[k] = a;
            end
            d = (cyc == rdc[k] + lat[k]) ? word_at(rda[k]) : $urandom;
            if (k == 0) i0.mem_data_in = d; else i1.mem_data_in = d;
        end
    endtask

    task automatic check_all();
        logic [6:0]  s, es;
        logic [31:0] a, p;
        logic [1:0]  c;
        int          o;
        bit          ld;
        for (int k = 0; k < 2; k++) begin
            get_out(k, s, a, p, c);
            o  = cyc - st[k];
            ld = act[k] && (o == 2 + lat[k]);
            es = {act[k], act[k] && o >= 1 && o <= 1 + lat[k], act[k] && o == 1,
                  act[k] && o == 0, ld, ld, ld};
            chk($sformatf("strobes%0d", k), 32'(s), 32'(es));
            chk($sformatf("mem_addr%0d", k), a, act[k] ? vec(mc[k]) : 32'd0);
            chk($sformatf("new_pc%0d", k), p, mpc[k]);
            chk($sformatf("cause%0d", k), 32'(c), 32'(mc[k]));
        end
    endtask

    task automatic step(input bit ov, input bit op, input bit en);
        i0.ovf_evt = ov; i1.ovf_evt = ov;
        i0.opcode_evt = op; i1.opcode_evt = op;
        i0.exc_enable = en; i1.exc_enable = en;
        @(posedge clk);
        model_edge(ov, op, en);
        cyc++;
        @(negedge clk);
        drive_mem();
        check_all();
    endtask

    task automatic run_idle();
        int n = 0;
        while ((act[0] || act[1]) && n < 20) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        lat[0] = L0; lat[1] = L1;
        reset = 1'b1;
        i0.ovf_evt = 1'b0; i0.opcode_evt = 1'b0; i0.exc_enable = 1'b0; i0.mem_data_in = 32'd0;
        i1.ovf_evt = 1'b0; i1.opcode_evt = 1'b0; i1.exc_enable = 1'b0; i1.mem_data_in = 32'd0;
        w254 = 32'h000000FF;
        w255 = 32'hAABBCC40;
        cyc  = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b1);

        // overflow entry, then opcode entry
        step(1'b1, 1'b0, 1'b1); run_idle();
        step(1'b0, 1'b1, 1'b1); run_idle();

        // simultaneous events: overflow wins
        w255 = 32'h12345677;
        step(1'b1, 1'b1, 1'b1); run_idle();

        // masked events
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // opcode pulses during an overflow sequence are ignored
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        run_idle();

        // asynchronous reset in WAIT
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_clear();
        check_all();
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1); run_idle();

        // back-to-back: event in the cycle right after exc_done of the short-latency instance
        w255 = 32'h000000A5;
        step(1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 10 && !(act[0] && cyc - st[0] == 2 + L0); n++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run_idle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            if (!act[0] && !act[1] && $urandom_range(0, 3) == 0) begin
                w254 = $urandom;
                w255 = $urandom;
            end
            r = $urandom_range(0, 11);
            step(r == 0 || r == 2, r == 1 || r == 2, $urandom_range(0, 4) != 0);
        end
        run_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
